// File: rtl/contador_modular_if.sv
// Control/status bundle for contador_modular. With CONTADOR_LAP_EN defined it also
// carries the laps signal.
interface contador_modular_if #(
  parameter int WIDTH     = 6,
  parameter int LAP_WIDTH = 8
);
  logic             start;
  logic             enable;
  logic             clear;
  logic [WIDTH-1:0] counter;
  logic             wrap;
  logic             busy;
  logic             done;
`ifdef CONTADOR_LAP_EN
  logic [LAP_WIDTH-1:0] laps;

  modport master (output start, enable, clear, input counter, wrap, busy, done, laps);
  modport slave  (input start, enable, clear, output counter, wrap, busy, done, laps);
`else
  modport master (output start, enable, clear, input counter, wrap, busy, done);
  modport slave  (input start, enable, clear, output counter, wrap, busy, done);
`endif

  if (WIDTH < 1 || LAP_WIDTH < 1) begin : g_bad_param
    $error("contador_modular_if: WIDTH and LAP_WIDTH must be >= 1");
  end
endinterface

// File: rtl/contador_modular.sv
// Modulo counter (0..MODULO-1) with free-run or one-shot sequencing, registered wrap
// pulse and busy/done status. Defining CONTADOR_LAP_EN adds a saturating lap counter.
module contador_modular #(
  parameter int WIDTH     = 6,
  parameter int MODULO    = 34,
  parameter int FREE_RUN  = 1,
  parameter int LAP_WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  contador_modular_if.slave cnt_if
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Terminal value is compared explicitly, so MODULO == 2^WIDTH never relies on overflow.
  localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(MODULO - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (cnt_if.clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (cnt_if.start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (cnt_if.enable) begin
            if (cnt_q == TERMINAL) begin
              cnt_d  = '0;
              wrap_d = 1'b1;
              if (FREE_RUN == 0) state_d = ST_DONE;
            end else if (cnt_q < TERMINAL) begin
              cnt_d = cnt_q + 1'b1;
            end else begin
              // Out-of-range value: recover to 0 silently, no wrap pulse.
              cnt_d = '0;
            end
          end
        end
        ST_DONE: begin
          cnt_d = '0;
          if (cnt_if.start) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  assign cnt_if.counter = cnt_q;
  assign cnt_if.wrap    = wrap_q;
  assign cnt_if.busy    = (state_q == ST_RUN);
  assign cnt_if.done    = (state_q == ST_DONE);

`ifdef CONTADOR_LAP_EN
  logic [LAP_WIDTH-1:0] laps_q, laps_d;
  logic                 start_ok;

  assign start_ok = cnt_if.start && !cnt_if.clear &&
                    ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    laps_d = laps_q;
    if (cnt_if.clear || start_ok) begin
      laps_d = '0;
    end else if (wrap_d && (laps_q != '1)) begin
      laps_d = laps_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      laps_q <= '0;
    end else begin
      laps_q <= laps_d;
    end
  end

  assign cnt_if.laps = laps_q;
`endif

  if (MODULO < 2 || MODULO > (1 << WIDTH) || LAP_WIDTH < 1) begin : g_bad_param
    $error("contador_modular: MODULO must be in 2..2^WIDTH and LAP_WIDTH >= 1");
  end

endmodule
